// File: rtl/packet_pkg.sv
// Shared types, header constants and byte-swap helpers for the packet builder.
package packet_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR0    = 2'd1,
      HDR1    = 2'd2,
      PAYLOAD = 2'd3
   } state_t;

   localparam int unsigned HDR_BYTES = 8;
   localparam int unsigned LEN_W     = 16;
   localparam int unsigned SID_W     = 16;
   localparam int unsigned SEQ_W     = 32;

   function automatic logic [15:0] bswap16(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/packet_seq_table.sv
// Per-stream sequence counters: one combinational read port, one write port
// (the builder writes seq+1 to advance a stream). Every entry resets to 1.
module packet_seq_table
   import packet_pkg::*;
#(
   parameter int unsigned NUM_STREAMS = 16,
   parameter int unsigned IDX_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [SEQ_W-1:0] rd_seq,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [SEQ_W-1:0] wr_seq
);

   logic [SEQ_W-1:0] seq_q [NUM_STREAMS];

   // Counter storage; asynchronous reset returns every stream to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_STREAMS); i++) begin
            seq_q[i] <= SEQ_W'(1);
         end
      end else if (wr_en) begin
         seq_q[wr_idx] <= wr_seq;
      end
   end

   assign rd_seq = seq_q[rd_idx];

endmodule

// File: rtl/packet_builder.sv
// Serializes one parallel message into a header + payload packet on a 32-bit
// valid/ready/last stream, numbering packets per stream.
// Optional feature: define PACKET_BUILDER_SEQ_OVERRIDE_EN to add i_seqOverride /
// i_seqValue, which replace the table sequence number for a packet.
module packet_builder
   import packet_pkg::*;
#(
   parameter int unsigned NUM_STREAMS = 16,
   parameter int unsigned MAX_WORDS   = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [32*MAX_WORDS-1:0] i_data,
   input  logic [3:0]              i_payloadWords,
   input  logic [SID_W-1:0]        i_streamId,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic [31:0]             o_data,
   output logic                    o_valid,
   output logic                    o_last,
   input  logic                    i_ready,
`ifdef PACKET_BUILDER_SEQ_OVERRIDE_EN
   input  logic                    i_seqOverride,
   input  logic [SEQ_W-1:0]        i_seqValue,
`endif
   output logic                    o_error
);

   localparam int unsigned IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   state_t                  state_q, state_d;
   logic [32*MAX_WORDS-1:0] pay_q, pay_d;
   logic [3:0]              words_q, words_d;
   logic [3:0]              rem_q, rem_d;
   logic [IDX_W-1:0]        sid_q, sid_d;
   logic [SEQ_W-1:0]        seq_q, seq_d;
   logic [31:0]             data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    error_q, error_d;

   logic [SEQ_W-1:0]        tbl_seq;
   logic [SEQ_W-1:0]        seq_sel;
   logic                    tbl_wr;
   logic [LEN_W-1:0]        msg_len;
   logic                    msg_bad;
   logic                    beat;

   packet_seq_table #(
      .NUM_STREAMS (NUM_STREAMS),
      .IDX_W       (IDX_W)
   ) u_seq_table (
      .clk    (i_clk),
      .rst    (i_rst),
      .rd_idx (i_streamId[IDX_W-1:0]),
      .rd_seq (tbl_seq),
      .wr_en  (tbl_wr),
      .wr_idx (sid_q),
      .wr_seq (seq_q + SEQ_W'(1))
   );

`ifdef PACKET_BUILDER_SEQ_OVERRIDE_EN
   assign seq_sel = i_seqOverride ? i_seqValue : tbl_seq;
`else
   assign seq_sel = tbl_seq;
`endif

   assign msg_len = LEN_W'(HDR_BYTES) + {10'b0, i_payloadWords, 2'b00};
   assign msg_bad = (i_payloadWords == 4'd0) ||
                    ({28'b0, i_payloadWords} > MAX_WORDS) ||
                    ({16'b0, i_streamId} >= NUM_STREAMS);
   assign beat    = valid_q && i_ready;

   // o_ready is the only unregistered output; held low through reset.
   assign o_ready = (state_q == IDLE) && !i_rst;
   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_last  = last_q;
   assign o_error = error_q;

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         pay_q   <= '0;
         words_q <= '0;
         rem_q   <= '0;
         sid_q   <= '0;
         seq_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pay_q   <= pay_d;
         words_q <= words_d;
         rem_q   <= rem_d;
         sid_q   <= sid_d;
         seq_q   <= seq_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         error_q <= error_d;
      end
   end

   // Next-state: each word is loaded into data_q one beat ahead so outputs stay registered.
   always_comb begin
      state_d = state_q;
      pay_d   = pay_q;
      words_d = words_q;
      rem_d   = rem_q;
      sid_d   = sid_q;
      seq_d   = seq_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      error_d = 1'b0;
      tbl_wr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               if (msg_bad) begin
                  error_d = 1'b1;
               end else begin
                  pay_d   = i_data;
                  words_d = i_payloadWords;
                  sid_d   = i_streamId[IDX_W-1:0];
                  seq_d   = seq_sel;
                  data_d  = {bswap16(msg_len), bswap16(i_streamId)};
                  valid_d = 1'b1;
                  last_d  = 1'b0;
                  state_d = HDR0;
               end
            end
         end
         HDR0: begin
            if (beat) begin
               data_d  = bswap32(seq_q);
               state_d = HDR1;
            end
         end
         HDR1: begin
            if (beat) begin
               data_d  = pay_q[31:0];
               pay_d   = pay_q >> 32;
               rem_d   = words_q - 4'd1;
               last_d  = (words_q == 4'd1);
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (beat) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  data_d  = '0;
                  tbl_wr  = 1'b1;
                  state_d = IDLE;
               end else begin
                  data_d  = pay_q[31:0];
                  pay_d   = pay_q >> 32;
                  rem_d   = rem_q - 4'd1;
                  last_d  = (rem_q == 4'd1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_packet_builder.sv
// Scoreboard bench for packet_builder: the driver queues expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_packet_builder;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [255:0]  i_data = '0;
   logic [3:0]    i_payloadWords = '0;
   logic [15:0]   i_streamId = '0;
   logic          i_valid = 1'b0;
   logic          i_ready = 1'b1;
   logic          o_ready;
   logic [31:0]   o_data;
   logic          o_valid;
   logic          o_last;
   logic          o_error;
`ifdef PACKET_BUILDER_SEQ_OVERRIDE_EN
   logic          i_seqOverride = 1'b0;
   logic [31:0]   i_seqValue = '0;
`endif

   packet_builder #(
      .NUM_STREAMS (16),
      .MAX_WORDS   (8)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_data         (i_data),
      .i_payloadWords (i_payloadWords),
      .i_streamId     (i_streamId),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .o_data         (o_data),
      .o_valid        (o_valid),
      .o_last         (o_last),
      .i_ready        (i_ready),
`ifdef PACKET_BUILDER_SEQ_OVERRIDE_EN
      .i_seqOverride  (i_seqOverride),
      .i_seqValue     (i_seqValue),
`endif
      .o_error        (o_error)
   );

   always #5 i_clk = ~i_clk;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [32:0] exp_q [$];
   logic [31:0] pw [8];

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a beat transfers at the next posedge iff o_valid && i_ready here.
   logic        hold_prev = 1'b0;
   logic [33:0] prev = '0;
   always @(negedge i_clk) begin
      logic [32:0] e;
      if (i_rst) begin
         hold_prev = 1'b0;
      end else begin
         if (o_valid) check("ready_low_when_busy", 34'(o_ready), 34'd0);
         if (hold_prev) check("hold_stable", {o_valid, o_last, o_data}, prev);
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 34'(o_valid), 34'd0);
            end else begin
               e = exp_q.pop_front();
               check("beat", {1'b0, o_last, o_data}, {1'b0, e});
            end
         end
         hold_prev = o_valid && !i_ready;
         prev      = {o_valid, o_last, o_data};
      end
   end

   // Offer one message; when ok, queue its hand-computed header and payload beats.
   task automatic send(input logic [15:0] sid, input logic [3:0] n, input bit ok,
                       input logic [31:0] h0, input logic [31:0] h1);
      int t;
      if (ok) begin
         exp_q.push_back({1'b0, h0});
         exp_q.push_back({1'b0, h1});
         for (int k = 0; k < int'(n); k++) exp_q.push_back({(k == int'(n) - 1), pw[k]});
      end
      for (int k = 0; k < 8; k++) i_data[32*k +: 32] = pw[k];
      i_streamId     = sid;
      i_payloadWords = n;
      i_valid        = 1'b1;
      t = 0;
      while (!o_ready && t < 50) begin
         @(posedge i_clk); #1;
         t++;
      end
      check("accept_wait", 34'(o_ready), 34'd1);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      if (ok) begin
         check("hdr0_latency", {o_valid, o_error}, 34'b10);
      end else begin
         check("error_pulse", {o_valid, o_error}, 34'b01);
         @(posedge i_clk); #1;
         check("error_once", {o_valid, o_error}, 34'b00);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || o_valid) && t < 200) begin
         @(posedge i_clk); #1;
         t++;
      end
      check("drain", {exp_q.size() != 0, o_valid}, 34'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      pw[0] = 32'h5A22B2D4; pw[1] = 32'h5A22B49E; pw[2] = 32'h42E3C71E; pw[3] = 32'h43995B7E;
      pw[4] = 32'h11112222; pw[5] = 32'h33334444; pw[6] = 32'h55556666; pw[7] = 32'h77778888;

      // Reset values.
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_outputs", {o_ready, o_valid, o_last, o_error, o_data}, 34'd0);
      i_rst = 1'b0;
      #1;
      check("ready_after_reset", 34'(o_ready), 34'd1);

      // Basic packet, plus IDLE re-entry timing (N+2 cycles after accept).
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0100_0000);
      t = 0;
      while (!o_ready && t < 20) begin
         @(posedge i_clk); #1;
         t++;
      end
      check("idle_gap", 34'(t), 34'd6);
      drain();

      // Sequence increments per stream, independently.
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0200_0000);
      drain();
      send(16'd3, 4'd4, 1'b1, 32'h1800_0300, 32'h0100_0000);
      drain();

      // Backpressure on payload word 1.
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0300_0000);
      repeat (3) begin
         @(posedge i_clk); #1;
      end
      check("bp_word1", {o_valid, o_last, o_data}, {2'b10, 32'h5A22B49E});
      i_ready = 1'b0;
      repeat (2) begin
         @(posedge i_clk); #1;
         check("bp_hold", {o_ready, o_valid, o_data}, {2'b01, 32'h5A22B49E});
      end
      i_ready = 1'b1;
      drain();

      // Rejections: zero words, too many words, stream out of range.
      send(16'd15, 4'd0, 1'b0, 32'h0, 32'h0);
      send(16'd15, 4'd9, 1'b0, 32'h0, 32'h0);
      send(16'd16, 4'd4, 1'b0, 32'h0, 32'h0);
      drain();
      send(16'd15, 4'd2, 1'b1, 32'h1000_0F00, 32'h0400_0000);
      drain();

      // Length extremes.
      send(16'd3, 4'd8, 1'b1, 32'h2800_0300, 32'h0200_0000);
      drain();
      send(16'd0, 4'd1, 1'b1, 32'h0C00_0000, 32'h0100_0000);
      drain();

      // Reset in the middle of a payload.
      send(16'd15, 4'd8, 1'b1, 32'h2800_0F00, 32'h0500_0000);
      repeat (4) begin
         @(posedge i_clk); #1;
      end
      i_rst = 1'b1;
      #1;
      check("reset_mid_packet", {o_ready, o_valid, o_last, o_data}, 34'd0);
      exp_q.delete();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      #1;
      check("ready_after_mid_reset", 34'(o_ready), 34'd1);
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0100_0000);
      drain();
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0200_0000);
      drain();
      send(16'd3, 4'd4, 1'b1, 32'h1800_0300, 32'h0100_0000);
      drain();

`ifdef PACKET_BUILDER_SEQ_OVERRIDE_EN
      // Override to the top of the range, then wrap; then inject a gap.
      i_seqOverride = 1'b1;
      i_seqValue    = 32'hFFFF_FFFF;
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'hFFFF_FFFF);
      i_seqOverride = 1'b0;
      drain();
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0000_0000);
      drain();
      i_seqOverride = 1'b1;
      i_seqValue    = 32'h0000_0004;
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0400_0000);
      i_seqOverride = 1'b0;
      drain();
      send(16'd15, 4'd4, 1'b1, 32'h1800_0F00, 32'h0500_0000);
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
